regfile_bytelane_wb: RTL and testbench

- Parametrised register-file write-back unit with an integrated register array.
- Decodes the CPU's extended "total" destination address into a register index and a per-byte-lane write mask. Generalises the 2-lane low/high scheme to N lanes.
- Holds one registered write-back stage. Commits byte-masked writes one cycle after acceptance.
- Provides two combinational read ports that bypass the pending write. Sits between the execute stage and operand fetch.

---
 rtl/regfile_bytelane_wb.sv | 135 +++++++++++++
 tb/tb_regfile_bytelane_wb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bytelane_wb.sv
// ============================================================================
// Module   : regfile_bytelane_wb
// Brief    : Register file with one registered, byte-lane-masked write-back
//            stage and two combinational read ports that bypass the pending
//            write. Optional build macro: REGFILE_ZERO_REG_EN (register 0
//            reads as zero and ignores writes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bytelane_wb #(
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,
  parameter int NUM_LANES    = DATA_W / 8,
  parameter int REG_ADDR_W   = $clog2(NUM_REGS),
  parameter int LANE_BITS    = $clog2(NUM_LANES),
  parameter int TOTAL_ADDR_W = REG_ADDR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [TOTAL_ADDR_W-1:0] wr_add,
  input  logic [NUM_LANES-1:0]    wr_lane_force,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  input  logic [REG_ADDR_W-1:0]   rd_add_a,
  output logic [DATA_W-1:0]       rd_data_a,
  input  logic [REG_ADDR_W-1:0]   rd_add_b,
  output logic [DATA_W-1:0]       rd_data_b,
  output logic                    wb_pending
);

  localparam int c_byte_idx_w = REG_ADDR_W - LANE_BITS;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  r_pending;
  logic [REG_ADDR_W-1:0] r_pend_idx;
  logic [NUM_LANES-1:0]  r_pend_mask;
  logic [DATA_W-1:0]     r_pend_data;

  logic                  w_byte_mode;
  logic [LANE_BITS-1:0]  w_lane;
  logic [REG_ADDR_W-1:0] w_idx;
  logic [NUM_LANES-1:0]  w_mask;
  logic [DATA_W-1:0]     w_data;
  logic                  w_accept;
  logic                  w_capture;

  assign wr_ready    = ~rst;
  assign w_accept    = wr_valid & wr_ready;
  assign w_byte_mode = wr_add[TOTAL_ADDR_W-1];
  assign w_lane      = wr_add[REG_ADDR_W-1 -: LANE_BITS];

  // Byte mode only reaches the lower registers: the lane field steals the top index bits.
  assign w_idx = w_byte_mode ? {{LANE_BITS{1'b0}}, wr_add[c_byte_idx_w-1:0]}
                             : wr_add[REG_ADDR_W-1:0];

  // Replicating the low byte lets one masked write path serve both modes.
  assign w_data = w_byte_mode ? {NUM_LANES{wr_data[7:0]}} : wr_data;

  always_comb begin
    w_mask = '0;
    if (w_byte_mode) begin
      w_mask[w_lane] = 1'b1;
    end else if (|wr_lane_force) begin
      w_mask = wr_lane_force;
    end else begin
      w_mask = '1;
    end
  end

`ifdef REGFILE_ZERO_REG_EN
  assign w_capture = w_accept && (w_idx != '0);
`else
  assign w_capture = w_accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_mask <= '0;
      r_pend_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (r_pending) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (r_pend_mask[k]) begin
            r_regs[r_pend_idx][k*8 +: 8] <= r_pend_data[k*8 +: 8];
          end
        end
      end
      r_pending <= w_capture;
      if (w_capture) begin
        r_pend_idx  <= w_idx;
        r_pend_mask <= w_mask;
        r_pend_data <= w_data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] merge_read(
    input logic [DATA_W-1:0]    arr_data,
    input logic                 hit,
    input logic [NUM_LANES-1:0] mask,
    input logic [DATA_W-1:0]    pend_data
  );
    logic [DATA_W-1:0] res;
    res = arr_data;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (hit && mask[k]) begin
        res[k*8 +: 8] = pend_data[k*8 +: 8];
      end
    end
    return res;
  endfunction

  always_comb begin
    rd_data_a = merge_read(r_regs[rd_add_a], r_pending && (rd_add_a == r_pend_idx),
                           r_pend_mask, r_pend_data);
    rd_data_b = merge_read(r_regs[rd_add_b], r_pending && (rd_add_b == r_pend_idx),
                           r_pend_mask, r_pend_data);
`ifdef REGFILE_ZERO_REG_EN
    if (rd_add_a == '0) rd_data_a = '0;
    if (rd_add_b == '0) rd_data_b = '0;
`endif
  end

  assign wb_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_regfile_bytelane_wb.sv
// ============================================================================
// Module   : tb_regfile_bytelane_wb
// Brief    : Self-checking bench for regfile_bytelane_wb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_bytelane_wb;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit c_zr = 1'b1;
`else
  localparam bit c_zr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [4:0]  wr_add;
  logic [1:0]  wr_lane_force;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  rd_add_a;
  logic [15:0] rd_data_a;
  logic [3:0]  rd_add_b;
  logic [15:0] rd_data_b;
  logic        wb_pending;

  int n_chk = 0;
  int n_err = 0;

  regfile_bytelane_wb dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_add       (wr_add),
    .wr_lane_force(wr_lane_force),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_add_a     (rd_add_a),
    .rd_data_a    (rd_data_a),
    .rd_add_b     (rd_add_b),
    .rd_data_b    (rd_data_b),
    .wb_pending   (wb_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [4:0]  a;
    logic [1:0]  f;
    logic [15:0] d;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ep;
    logic        er;
  } vec_t;

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ep;
    logic        er;
  } exp_t;

  exp_t sbq[$];
  logic [15:0] model [16];

  function automatic vec_t mk(input logic r, input logic v, input logic [4:0] a,
                              input logic [1:0] f, input logic [15:0] d,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic ep, input logic er);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.f = f; t.d = d;
    t.ra = ra; t.rb = rb; t.ea = ea; t.eb = eb; t.ep = ep; t.er = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge.
  task automatic step(input vec_t t, input string nm);
    exp_t e;
    @(negedge clk);
    rst = t.r; wr_valid = t.v; wr_add = t.a; wr_lane_force = t.f; wr_data = t.d;
    rd_add_a = t.ra; rd_add_b = t.rb;
    sbq.push_back('{t.ea, t.eb, t.ep, t.er});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({nm, " rd_a"},    rd_data_a,         e.ea);
    chk({nm, " rd_b"},    rd_data_b,         e.eb);
    chk({nm, " pending"}, {15'd0, wb_pending}, {15'd0, e.ep});
    chk({nm, " ready"},   {15'd0, wr_ready},   {15'd0, e.er});
  endtask

  vec_t tbl [17];

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_add = '0; wr_lane_force = '0; wr_data = '0;
    rd_add_a = '0; rd_add_b = '0;

    // Reset then sweep every index on both ports.
    step(mk(1, 0, 5'h00, 2'b00, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 0), "reset");
    step(mk(0, 0, 5'h00, 2'b00, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 1), "idle");
    for (int i = 0; i < 16; i++) begin
      rd_add_a = 4'(i);
      rd_add_b = 4'(15 - i);
      #1;
      chk($sformatf("sweep a%0d", i), rd_data_a, 16'h0000);
      chk($sformatf("sweep b%0d", 15 - i), rd_data_b, 16'h0000);
    end

    //              r  v  add    frc    data      ra  rb  exp_a     exp_b    ep er
    tbl[0]  = mk(1, 0, 5'h00, 2'b00, 16'h0000, 0,  15, 16'h0000, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 5'h03, 2'b00, 16'hABCD, 3,  0,  16'hABCD, 16'h0000, 1, 1);
    tbl[2]  = mk(0, 0, 5'h00, 2'b00, 16'h0000, 3,  3,  16'hABCD, 16'hABCD, 0, 1);
    tbl[3]  = mk(0, 1, 5'h02, 2'b00, 16'h1234, 2,  3,  16'h1234, 16'hABCD, 1, 1);
    tbl[4]  = mk(0, 1, 5'h1A, 2'b00, 16'h0055, 2,  2,  16'h5534, 16'h5534, 1, 1);
    tbl[5]  = mk(0, 0, 5'h00, 2'b00, 16'h0000, 2,  2,  16'h5534, 16'h5534, 0, 1);
    tbl[6]  = mk(0, 1, 5'h05, 2'b00, 16'hFFFF, 5,  2,  16'hFFFF, 16'h5534, 1, 1);
    tbl[7]  = mk(0, 1, 5'h05, 2'b01, 16'h7788, 5,  5,  16'hFF88, 16'hFF88, 1, 1);
    tbl[8]  = mk(0, 1, 5'h05, 2'b10, 16'h1100, 5,  2,  16'h1188, 16'h5534, 1, 1);
    tbl[9]  = mk(0, 1, 5'h12, 2'b00, 16'h00AA, 5,  2,  16'h1188, 16'h55AA, 1, 1);
    tbl[10] = mk(0, 1, 5'h1A, 2'b00, 16'h00BB, 2,  2,  16'hBBAA, 16'hBBAA, 1, 1);
    tbl[11] = mk(0, 0, 5'h00, 2'b00, 16'h0000, 2,  5,  16'hBBAA, 16'h1188, 0, 1);
    tbl[12] = mk(0, 1, 5'h1B, 2'b01, 16'h12EF, 3,  3,  16'hEFCD, 16'hEFCD, 1, 1);
    tbl[13] = mk(0, 0, 5'h00, 2'b00, 16'h0000, 3,  0,  16'hEFCD, 16'h0000, 0, 1);
    tbl[14] = mk(0, 1, 5'h17, 2'b00, 16'h3344, 7,  7,  16'h0044, 16'h0044, 1, 1);
    tbl[15] = mk(0, 1, 5'h0F, 2'b00, 16'hBEEF, 7,  15, 16'h0044, 16'hBEEF, 1, 1);
    tbl[16] = mk(0, 0, 5'h00, 2'b00, 16'h0000, 15, 7,  16'hBEEF, 16'h0044, 0, 1);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset on the commit edge discards the pending write.
    step(mk(0, 1, 5'h04, 2'b00, 16'h9999, 4, 4, 16'h9999, 16'h9999, 1, 1), "rcommit acc");
    step(mk(1, 0, 5'h00, 2'b00, 16'h0000, 4, 2, 16'h0000, 16'h0000, 0, 0), "rcommit rst");
    // A write presented during reset is dropped.
    step(mk(1, 1, 5'h06, 2'b00, 16'h5555, 6, 4, 16'h0000, 16'h0000, 0, 0), "rstwr");
    step(mk(0, 0, 5'h00, 2'b00, 16'h0000, 6, 4, 16'h0000, 16'h0000, 0, 1), "rstwr after");

    // Register 0 behaviour depends on build option.
    step(mk(0, 1, 5'h00, 2'b00, 16'h1234, 0, 0, c_zr ? 16'h0000 : 16'h1234,
            c_zr ? 16'h0000 : 16'h1234, !c_zr, 1), "reg0 acc");
    step(mk(0, 0, 5'h00, 2'b00, 16'h0000, 0, 0, c_zr ? 16'h0000 : 16'h1234,
            c_zr ? 16'h0000 : 16'h1234, 0, 1), "reg0 commit");

    // Randomised traffic against a visible-state model.
    step(mk(1, 0, 5'h00, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0), "rand rst");
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    for (int n = 0; n < 60; n++) begin
      vec_t t;
      logic [3:0] idx;
      logic [1:0] msk;
      logic [15:0] al;
      t.r = 1'b0;
      t.v = ($urandom_range(0, 3) != 0);
      t.a = 5'($urandom);
      t.f = 2'($urandom);
      t.d = 16'($urandom);
      t.ra = 4'($urandom);
      t.rb = 4'($urandom);
      if (t.a[4]) begin
        idx = {1'b0, t.a[2:0]};
        msk = t.a[3] ? 2'b10 : 2'b01;
        al  = {t.d[7:0], t.d[7:0]};
      end else begin
        idx = t.a[3:0];
        msk = (t.f != 2'b00) ? t.f : 2'b11;
        al  = t.d;
      end
      if (t.v && !(c_zr && idx == 4'd0)) begin
        if (msk[0]) model[idx][7:0]  = al[7:0];
        if (msk[1]) model[idx][15:8] = al[15:8];
      end
      t.ea = (c_zr && t.ra == 4'd0) ? 16'h0000 : model[t.ra];
      t.eb = (c_zr && t.rb == 4'd0) ? 16'h0000 : model[t.rb];
      t.ep = t.v && !(c_zr && idx == 4'd0);
      t.er = 1'b1;
      step(t, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
